// File: rtl/wb_generic_byte_en_sram_bridge.sv
// Wishbone classic slave to single-port synchronous SRAM bridge with per-byte
// write enables, configurable read latency and out-of-range error response.
module wb_generic_byte_en_sram_bridge #(
  parameter int unsigned ADDRESS_WIDTH = 12,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned SRAM_DEPTH    = 1024,
  parameter int unsigned READ_LATENCY  = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [ADDRESS_WIDTH-1:0]      wb_adr_i,
  input  logic [DATA_WIDTH-1:0]         wb_dat_i,
  output logic [DATA_WIDTH-1:0]         wb_dat_o,
  input  logic [DATA_WIDTH/8-1:0]       wb_sel_i,
  input  logic                          wb_we_i,
  input  logic                          wb_cyc_i,
  input  logic                          wb_stb_i,
  output logic                          wb_ack_o,
  output logic                          wb_err_o,
  output logic [$clog2(SRAM_DEPTH)-1:0] sram_addr,
  output logic                          sram_read_en,
  output logic                          sram_write_en,
  output logic [DATA_WIDTH/8-1:0]       sram_byte_en,
  output logic [DATA_WIDTH-1:0]         sram_write_data,
  input  logic [DATA_WIDTH-1:0]         sram_read_data
);

  localparam int unsigned BW  = DATA_WIDTH / 8;
  localparam int unsigned OFS = $clog2(BW);
  localparam int unsigned IW  = ADDRESS_WIDTH - OFS;
  localparam int unsigned SAW = $clog2(SRAM_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RD_WAIT,
    RESP
  } state_t;

  state_t state, next_state;

  logic [IW-1:0]         idx;
  logic                  in_range;
  logic                  req;
  logic                  rd_done;
  logic                  access;
  logic [SAW-1:0]        addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [BW-1:0]         sel_q;
  logic                  we_q;
  logic                  err_q;
  logic                  abort_q;
  logic [2:0]            cnt_q;
  logic [DATA_WIDTH-1:0] dat_q;

  assign idx      = wb_adr_i[ADDRESS_WIDTH-1:OFS];
  assign in_range = 32'(idx) < SRAM_DEPTH;
  assign req      = wb_cyc_i & wb_stb_i;
  assign rd_done  = (state == RD_WAIT) && (cnt_q == 3'd0);
  assign wb_dat_o = dat_q;

  if (OFS > 0) begin : g_low_adr
    logic unused_low_adr;
    assign unused_low_adr = ^wb_adr_i[OFS-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Out-of-range requests still pass through ACCESS (with strobes suppressed)
  // so that ERR lands on the same cycle a write ACK would.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req) next_state = ACCESS;
      ACCESS: begin
        if (we_q || err_q) next_state = wb_cyc_i ? RESP : IDLE;
        else               next_state = RD_WAIT;
      end
      RD_WAIT: if (cnt_q == 3'd0) next_state = (wb_cyc_i && !abort_q) ? RESP : IDLE;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      abort_q <= 1'b0;
      cnt_q   <= '0;
      dat_q   <= '0;
    end else begin
      if (state == IDLE && req) begin
        addr_q  <= idx[SAW-1:0];
        wdata_q <= wb_dat_i;
        sel_q   <= wb_sel_i;
        we_q    <= wb_we_i;
        err_q   <= !in_range;
        abort_q <= 1'b0;
      end
      // An abort lets the issued read drain but suppresses its response.
      if (state == ACCESS || state == RD_WAIT) abort_q <= abort_q | !wb_cyc_i;
      if (state == ACCESS)                      cnt_q <= 3'(READ_LATENCY - 1);
      else if (state == RD_WAIT && cnt_q != 0)  cnt_q <= cnt_q - 3'd1;
      if (rd_done) dat_q <= sram_read_data;
    end
  end

  always_comb begin
    access          = (state == ACCESS) && !err_q;
    sram_read_en    = access && !we_q;
    sram_write_en   = access && we_q;
    sram_addr       = access ? addr_q : '0;
    sram_byte_en    = access ? sel_q : '0;
    sram_write_data = (access && we_q) ? wdata_q : '0;
    wb_ack_o        = (state == RESP) && !err_q && wb_cyc_i;
    wb_err_o        = (state == RESP) && err_q && wb_cyc_i;
  end

endmodule

// File: tb/tb_wb_generic_byte_en_sram_bridge.sv
// Directed bench: five bridge instances (read latency 1..4, plus a 768-word
// variant) each with a behavioural SRAM, driven from a vector table.
module tb_wb_generic_byte_en_sram_bridge;

  localparam int NI = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [11:0] adr [NI];
  logic [31:0] wdat [NI];
  logic [3:0]  sel [NI];
  logic        we [NI];
  logic        cyc [NI];
  logic        stb [NI];
  logic [31:0] rdat_o [NI];
  logic        ack [NI];
  logic        err [NI];
  logic        re [NI];
  logic        wen [NI];
  logic [9:0]  saddr [NI];
  logic [3:0]  ben [NI];
  logic [31:0] swd [NI];

  int n_cmp = 0;
  int n_fail = 0;
  int n_rd [NI];
  int n_wr [NI];
  int n_ack [NI];
  int n_err [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned RL    = (g == 4) ? 1 : g + 1;
    localparam int unsigned DEPTH = (g == 4) ? 768 : 1024;
    logic [31:0] mem [1024];
    logic [31:0] pipe [4];

    always_ff @(posedge clk) begin
      if (wen[g])
        for (int b = 0; b < 4; b++)
          if (ben[g][b]) mem[saddr[g]][8*b +: 8] <= swd[g][8*b +: 8];
      pipe[0] <= re[g] ? mem[saddr[g]] : 32'h0BAD0BAD;
      for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
    end

    wb_generic_byte_en_sram_bridge #(
      .ADDRESS_WIDTH(12),
      .DATA_WIDTH(32),
      .SRAM_DEPTH(DEPTH),
      .READ_LATENCY(RL)
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .wb_adr_i(adr[g]),
      .wb_dat_i(wdat[g]),
      .wb_dat_o(rdat_o[g]),
      .wb_sel_i(sel[g]),
      .wb_we_i(we[g]),
      .wb_cyc_i(cyc[g]),
      .wb_stb_i(stb[g]),
      .wb_ack_o(ack[g]),
      .wb_err_o(err[g]),
      .sram_addr(saddr[g]),
      .sram_read_en(re[g]),
      .sram_write_en(wen[g]),
      .sram_byte_en(ben[g]),
      .sram_write_data(swd[g]),
      .sram_read_data(pipe[RL-1])
    );
  end

  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (re[k])  n_rd[k]++;
      if (wen[k]) n_wr[k]++;
      if (ack[k]) n_ack[k]++;
      if (err[k]) n_err[k]++;
      if (ack[k] && err[k]) begin
        n_fail++;
        $display("FAIL proto%0d: ack=%0b err=%0b required not both high", k, ack[k], err[k]);
      end
      if ((ack[k] || err[k]) && !cyc[k]) begin
        n_fail++;
        $display("FAIL proto%0d: ack/err=%0b while cyc=0, required 0", k, ack[k] | err[k]);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h", nm, a, e);
    end
  endtask

  typedef struct {
    int        k;
    bit        we;
    bit [11:0] adr;
    bit [31:0] dat;
    bit [3:0]  sel;
    int        lat;
    bit        err;
    bit [31:0] rdat;
  } vec_t;

  vec_t vt [23];

  task automatic run_vec(input int idx, input vec_t v);
    int k;
    int lat;
    int strobes0;
    bit got_err;
    bit done;
    logic [31:0] rd;
    logic t1_re, t1_wen;
    logic [9:0] t1_addr;
    logic [3:0] t1_ben;
    logic [31:0] t1_wd;
    k = v.k;
    lat = 0;
    got_err = 1'b0;
    done = 1'b0;
    rd = '0;
    t1_re = 1'b0; t1_wen = 1'b0; t1_addr = '0; t1_ben = '0; t1_wd = '0;
    strobes0 = n_rd[k] + n_wr[k];
    @(negedge clk);
    adr[k] = v.adr; wdat[k] = v.dat; sel[k] = v.sel; we[k] = v.we;
    cyc[k] = 1'b1; stb[k] = 1'b1;
    for (int n = 1; n <= 20 && !done; n++) begin
      @(negedge clk);
      if (n == 1) begin
        t1_re = re[k]; t1_wen = wen[k]; t1_addr = saddr[k]; t1_ben = ben[k]; t1_wd = swd[k];
      end
      if (ack[k] || err[k]) begin
        lat = n; got_err = err[k]; rd = rdat_o[k]; done = 1'b1;
      end
    end
    @(posedge clk);
    #1 stb[k] = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d.pulse_end", idx), 32'(ack[k] | err[k]), 32'd0);
    cyc[k] = 1'b0; we[k] = 1'b0;
    chk($sformatf("v%0d.latency", idx), lat, v.lat);
    chk($sformatf("v%0d.is_err", idx), 32'(got_err), 32'(v.err));
    chk($sformatf("v%0d.strobes", idx), n_rd[k] + n_wr[k] - strobes0, v.err ? 0 : 1);
    if (!v.err && !v.we) chk($sformatf("v%0d.rdata", idx), rd, v.rdat);
    if (v.err) begin
      chk($sformatf("v%0d.t1_re", idx), 32'(t1_re), 32'd0);
      chk($sformatf("v%0d.t1_wen", idx), 32'(t1_wen), 32'd0);
    end else begin
      chk($sformatf("v%0d.t1_re", idx), 32'(t1_re), 32'(!v.we));
      chk($sformatf("v%0d.t1_wen", idx), 32'(t1_wen), 32'(v.we));
      chk($sformatf("v%0d.t1_addr", idx), 32'(t1_addr), 32'(v.adr[11:2]));
      if (v.we) begin
        chk($sformatf("v%0d.t1_ben", idx), 32'(t1_ben), 32'(v.sel));
        chk($sformatf("v%0d.t1_wdata", idx), t1_wd, v.dat);
      end
    end
  endtask

  initial begin
    int a0, e0, r0;
    for (int k = 0; k < NI; k++) begin
      adr[k] = '0; wdat[k] = '0; sel[k] = '0; we[k] = 1'b0; cyc[k] = 1'b0; stb[k] = 1'b0;
      n_rd[k] = 0; n_wr[k] = 0; n_ack[k] = 0; n_err[k] = 0;
    end
    //          k  we     adr      dat           sel   lat err   rdat
    vt[0]  = '{0, 1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 2, 1'b0, 32'h0};
    vt[1]  = '{0, 1'b0, 12'h010, 32'h0,        4'hF, 3, 1'b0, 32'hDEADBEEF};
    vt[2]  = '{0, 1'b1, 12'h010, 32'h11223344, 4'hF, 2, 1'b0, 32'h0};
    vt[3]  = '{0, 1'b1, 12'h010, 32'hAABBCCDD, 4'h5, 2, 1'b0, 32'h0};
    vt[4]  = '{0, 1'b0, 12'h011, 32'h0,        4'h0, 3, 1'b0, 32'h11BB33DD};
    vt[5]  = '{0, 1'b1, 12'h020, 32'hA5A5A5A5, 4'hF, 2, 1'b0, 32'h0};
    vt[6]  = '{0, 1'b1, 12'h020, 32'h12345678, 4'h0, 2, 1'b0, 32'h0};
    vt[7]  = '{0, 1'b0, 12'h020, 32'h0,        4'hF, 3, 1'b0, 32'hA5A5A5A5};
    vt[8]  = '{0, 1'b1, 12'hFFC, 32'hC0DE0001, 4'hF, 2, 1'b0, 32'h0};
    vt[9]  = '{0, 1'b0, 12'hFFF, 32'h0,        4'hF, 3, 1'b0, 32'hC0DE0001};
    vt[10] = '{1, 1'b1, 12'hFFC, 32'hC0DE0002, 4'hF, 2, 1'b0, 32'h0};
    vt[11] = '{1, 1'b0, 12'hFFC, 32'h0,        4'hF, 4, 1'b0, 32'hC0DE0002};
    vt[12] = '{2, 1'b1, 12'hFFC, 32'hC0DE0003, 4'hF, 2, 1'b0, 32'h0};
    vt[13] = '{2, 1'b0, 12'hFFC, 32'h0,        4'hF, 5, 1'b0, 32'hC0DE0003};
    vt[14] = '{3, 1'b1, 12'hFFC, 32'hC0DE0004, 4'hF, 2, 1'b0, 32'h0};
    vt[15] = '{3, 1'b0, 12'hFFC, 32'h0,        4'hF, 6, 1'b0, 32'hC0DE0004};
    vt[16] = '{4, 1'b0, 12'hC00, 32'h0,        4'hF, 2, 1'b1, 32'h0};
    vt[17] = '{4, 1'b1, 12'hBFC, 32'h76767676, 4'hF, 2, 1'b0, 32'h0};
    vt[18] = '{4, 1'b0, 12'hBFC, 32'h0,        4'hF, 3, 1'b0, 32'h76767676};
    vt[19] = '{4, 1'b1, 12'hFFC, 32'h01010101, 4'hF, 2, 1'b1, 32'h0};
    vt[20] = '{4, 1'b0, 12'hBFC, 32'h0,        4'hF, 3, 1'b0, 32'h76767676};
    vt[21] = '{1, 1'b1, 12'h040, 32'h5A5A0F0F, 4'hF, 2, 1'b0, 32'h0};
    vt[22] = '{1, 1'b0, 12'h040, 32'h0,        4'hF, 4, 1'b0, 32'h5A5A0F0F};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("rst%0d.ack", k), 32'(ack[k]), 32'd0);
      chk($sformatf("rst%0d.err", k), 32'(err[k]), 32'd0);
      chk($sformatf("rst%0d.re", k), 32'(re[k]), 32'd0);
      chk($sformatf("rst%0d.wen", k), 32'(wen[k]), 32'd0);
      chk($sformatf("rst%0d.addr", k), 32'(saddr[k]), 32'd0);
      chk($sformatf("rst%0d.ben", k), 32'(ben[k]), 32'd0);
      chk($sformatf("rst%0d.wdata", k), swd[k], 32'd0);
      chk($sformatf("rst%0d.dat_o", k), rdat_o[k], 32'd0);
    end
    rst = 1'b0;

    for (int i = 0; i <= 20; i++) run_vec(i, vt[i]);

    // Abort on the latency-2 instance: cyc drops in ACCESS, comes back idle.
    a0 = n_ack[1]; e0 = n_err[1]; r0 = n_rd[1];
    @(negedge clk);
    adr[1] = 12'h010; we[1] = 1'b0; sel[1] = 4'hF; cyc[1] = 1'b1; stb[1] = 1'b1;
    @(negedge clk);
    chk("abort.t1_re", 32'(re[1]), 32'd1);
    cyc[1] = 1'b0; stb[1] = 1'b0;
    @(negedge clk);
    cyc[1] = 1'b1;
    repeat (8) @(negedge clk);
    cyc[1] = 1'b0;
    chk("abort.acks", n_ack[1] - a0, 0);
    chk("abort.errs", n_err[1] - e0, 0);
    chk("abort.reads", n_rd[1] - r0, 1);

    for (int i = 21; i <= 22; i++) run_vec(i, vt[i]);

    // Reset while the latency-3 instance sits in RD_WAIT; cyc stays high.
    a0 = n_ack[2]; e0 = n_err[2];
    @(negedge clk);
    adr[2] = 12'hFFC; we[2] = 1'b0; sel[2] = 4'hF; cyc[2] = 1'b1; stb[2] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1; stb[2] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid.ack", 32'(ack[2]), 32'd0);
    chk("rstmid.re", 32'(re[2]), 32'd0);
    chk("rstmid.dat_o", rdat_o[2], 32'd0);
    repeat (8) @(negedge clk);
    chk("rstmid.acks", n_ack[2] - a0, 0);
    chk("rstmid.errs", n_err[2] - e0, 0);
    cyc[2] = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
